// File: rtl/axi_cmd_master_pkg.sv
// Shared types for axi_cmd_master: FSM states, latched command/response payloads, AXI constants.
// Command/response structs are sized for the 64-bit default configuration.
package axi_cmd_master_pkg;

  localparam int unsigned CmdAddrWidth = 64;
  localparam int unsigned CmdDataWidth = 64;
  localparam int unsigned CmdStrbWidth = CmdDataWidth / 8;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP,
    FAULT
  } state_e;

  typedef struct packed {
    logic                    we;
    logic [CmdAddrWidth-1:0] addr;
    logic [CmdDataWidth-1:0] wdata;
    logic [CmdStrbWidth-1:0] strb;
    logic [2:0]              size;
  } cmd_t;

  typedef struct packed {
    logic [CmdDataWidth-1:0] rdata;
    logic [1:0]              resp;
    logic                    err;
    logic                    tmo;
  } rsp_t;

endpackage

// File: rtl/axi_cmd_master_if.sv
// Thin AXI4 bus bundle; the only piece that changes when wiring the master onto a crossbar slave port.
interface axi_cmd_master_intf #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned UserWidth = 64
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [IdWidth-1:0]   aw_id;
  logic [AddrWidth-1:0] aw_addr;
  logic [7:0]           aw_len;
  logic [2:0]           aw_size;
  logic [1:0]           aw_burst;
  logic                 aw_lock;
  logic [3:0]           aw_cache;
  logic [2:0]           aw_prot;
  logic [3:0]           aw_qos;
  logic [3:0]           aw_region;
  logic [5:0]           aw_atop;
  logic [UserWidth-1:0] aw_user;
  logic                 aw_valid;
  logic                 aw_ready;

  logic [DataWidth-1:0] w_data;
  logic [StrbWidth-1:0] w_strb;
  logic                 w_last;
  logic [UserWidth-1:0] w_user;
  logic                 w_valid;
  logic                 w_ready;

  logic [IdWidth-1:0]   b_id;
  logic [1:0]           b_resp;
  logic [UserWidth-1:0] b_user;
  logic                 b_valid;
  logic                 b_ready;

  logic [IdWidth-1:0]   ar_id;
  logic [AddrWidth-1:0] ar_addr;
  logic [7:0]           ar_len;
  logic [2:0]           ar_size;
  logic [1:0]           ar_burst;
  logic                 ar_lock;
  logic [3:0]           ar_cache;
  logic [2:0]           ar_prot;
  logic [3:0]           ar_qos;
  logic [3:0]           ar_region;
  logic [UserWidth-1:0] ar_user;
  logic                 ar_valid;
  logic                 ar_ready;

  logic [IdWidth-1:0]   r_id;
  logic [DataWidth-1:0] r_data;
  logic [1:0]           r_resp;
  logic                 r_last;
  logic [UserWidth-1:0] r_user;
  logic                 r_valid;
  logic                 r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_cmd_master.sv
// Single-outstanding AXI4 master: one command in, one single-beat AXI transaction, one response out.
// A handshake timeout reports an error and parks the block in FAULT until reset.
module axi_cmd_master
  import axi_cmd_master_pkg::*;
#(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned UserWidth     = 64,
  parameter int unsigned IdValue       = 0,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned StrbWidth    = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [DataWidth-1:0] cmd_wdata_i,
  input  logic [StrbWidth-1:0] cmd_strb_i,
  input  logic [2:0]           cmd_size_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic [1:0]           rsp_resp_o,
  output logic                 rsp_err_o,
  output logic                 rsp_tmo_o,
  axi_cmd_master_intf.master   axi
);

  localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  state_e              state_q;
  cmd_t                cmd_q;
  rsp_t                rsp_q;
  logic [CntWidth-1:0] cnt_q;
  logic                cmd_ready_q, rsp_valid_q;
  logic                aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q;
  logic                aw_done_q, w_done_q;

  logic                aw_hs_d, w_hs_d, ar_hs_d, b_hs_d, r_hs_d, rsp_hs_d;
  logic                tmo_hit_d, id_bad_d;
  logic [IdWidth-1:0]  rx_id_d;

  assign aw_hs_d  = aw_valid_q & axi.aw_ready;
  assign w_hs_d   = w_valid_q & axi.w_ready;
  assign ar_hs_d  = ar_valid_q & axi.ar_ready;
  assign b_hs_d   = b_ready_q & axi.b_valid;
  assign r_hs_d   = r_ready_q & axi.r_valid;
  assign rsp_hs_d = rsp_valid_q & rsp_ready_i;

  assign tmo_hit_d = (TimeoutCycles != 0) && (cnt_q == CntWidth'(TimeoutCycles));
  // Only one of B/R can be pending, so the ID check follows the latched direction.
  assign rx_id_d   = cmd_q.we ? axi.b_id : axi.r_id;
  assign id_bad_d  = rx_id_d != IdWidth'(IdValue);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      b_ready_q   <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (cmd_ready_q && cmd_valid_i) begin
            cmd_ready_q <= 1'b0;
            cmd_q       <= '{we:    cmd_we_i,
                             addr:  CmdAddrWidth'(cmd_addr_i),
                             wdata: CmdDataWidth'(cmd_wdata_i),
                             strb:  CmdStrbWidth'(cmd_strb_i),
                             size:  cmd_size_i};
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            if (cmd_we_i) begin
              state_q    <= WR_REQ;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              state_q    <= RD_REQ;
              ar_valid_q <= 1'b1;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        WR_REQ: begin
          cnt_q <= cnt_q + CntWidth'(1);
          if (aw_hs_d) begin
            aw_valid_q <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_hs_d) begin
            w_valid_q <= 1'b0;
            w_done_q  <= 1'b1;
          end
          if ((aw_done_q | aw_hs_d) && (w_done_q | w_hs_d)) begin
            state_q   <= WR_RESP;
            b_ready_q <= 1'b1;
            cnt_q     <= '0;
          end else if (tmo_hit_d) begin
            state_q     <= RSP;
            rsp_q       <= '{rdata: '0, resp: OKAY, err: 1'b1, tmo: 1'b1};
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
          end
        end

        WR_RESP: begin
          cnt_q <= cnt_q + CntWidth'(1);
          if (b_hs_d) begin
            state_q     <= RSP;
            b_ready_q   <= 1'b0;
            rsp_q       <= '{rdata: '0, resp: axi.b_resp,
                             err: (axi.b_resp != OKAY) | id_bad_d, tmo: 1'b0};
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
          end else if (tmo_hit_d) begin
            state_q     <= RSP;
            b_ready_q   <= 1'b0;
            rsp_q       <= '{rdata: '0, resp: OKAY, err: 1'b1, tmo: 1'b1};
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
          end
        end

        RD_REQ: begin
          cnt_q <= cnt_q + CntWidth'(1);
          if (ar_hs_d) begin
            state_q    <= RD_RESP;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            cnt_q      <= '0;
          end else if (tmo_hit_d) begin
            state_q     <= RSP;
            rsp_q       <= '{rdata: '0, resp: OKAY, err: 1'b1, tmo: 1'b1};
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
          end
        end

        RD_RESP: begin
          cnt_q <= cnt_q + CntWidth'(1);
          if (r_hs_d) begin
            state_q     <= RSP;
            r_ready_q   <= 1'b0;
            rsp_q       <= '{rdata: CmdDataWidth'(axi.r_data), resp: axi.r_resp,
                             err: (axi.r_resp != OKAY) | id_bad_d | ~axi.r_last, tmo: 1'b0};
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
          end else if (tmo_hit_d) begin
            state_q     <= RSP;
            r_ready_q   <= 1'b0;
            rsp_q       <= '{rdata: '0, resp: OKAY, err: 1'b1, tmo: 1'b1};
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
          end
        end

        RSP: begin
          cnt_q <= '0;
          if (rsp_hs_d) begin
            rsp_valid_q <= 1'b0;
            if (rsp_q.tmo) begin
              state_q <= FAULT;
            end else begin
              state_q     <= IDLE;
              cmd_ready_q <= 1'b1;
            end
          end
        end

        // Abandoned AXI valids stay up here; only reset clears them.
        FAULT: begin
          cnt_q       <= '0;
          cmd_ready_q <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = DataWidth'(rsp_q.rdata);
  assign rsp_resp_o  = rsp_q.resp;
  assign rsp_err_o   = rsp_q.err;
  assign rsp_tmo_o   = rsp_q.tmo;

  assign axi.aw_id     = IdWidth'(IdValue);
  assign axi.aw_addr   = AddrWidth'(cmd_q.addr);
  assign axi.aw_len    = '0;
  assign axi.aw_size   = cmd_q.size;
  assign axi.aw_burst  = BURST_INCR;
  assign axi.aw_lock   = 1'b0;
  assign axi.aw_cache  = '0;
  assign axi.aw_prot   = '0;
  assign axi.aw_qos    = '0;
  assign axi.aw_region = '0;
  assign axi.aw_atop   = '0;
  assign axi.aw_user   = '0;
  assign axi.aw_valid  = aw_valid_q;

  assign axi.w_data  = DataWidth'(cmd_q.wdata);
  assign axi.w_strb  = StrbWidth'(cmd_q.strb);
  assign axi.w_last  = 1'b1;
  assign axi.w_user  = '0;
  assign axi.w_valid = w_valid_q;

  assign axi.b_ready = b_ready_q;

  assign axi.ar_id     = IdWidth'(IdValue);
  assign axi.ar_addr   = AddrWidth'(cmd_q.addr);
  assign axi.ar_len    = '0;
  assign axi.ar_size   = cmd_q.size;
  assign axi.ar_burst  = BURST_INCR;
  assign axi.ar_lock   = 1'b0;
  assign axi.ar_cache  = '0;
  assign axi.ar_prot   = '0;
  assign axi.ar_qos    = '0;
  assign axi.ar_region = '0;
  assign axi.ar_user   = '0;
  assign axi.ar_valid  = ar_valid_q;

  assign axi.r_ready = r_ready_q;

endmodule

// File: tb/tb_axi_cmd_master.sv
// Directed bench for axi_cmd_master: the bench plays the AXI slave cycle by cycle.
module tb_axi_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [63:0] cmd_addr, cmd_wdata;
  logic [7:0]  cmd_strb;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  int checks   = 0;
  int failures = 0;
  int aw_beats = 0;
  int w_beats  = 0;
  logic [63:0] w_seen = '0;

  always #5 clk = ~clk;

  axi_cmd_master_intf #(.AddrWidth(64), .DataWidth(64), .IdWidth(4), .UserWidth(64)) axi ();

  axi_cmd_master #(
    .AddrWidth(64), .DataWidth(64), .IdWidth(4), .UserWidth(64),
    .IdValue(0), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb), .cmd_size_i(cmd_size),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_resp_o(rsp_resp), .rsp_err_o(rsp_err), .rsp_tmo_o(rsp_tmo),
    .axi(axi.master)
  );

  always @(posedge clk) begin
    if (axi.aw_valid && axi.aw_ready) aw_beats++;
    if (axi.w_valid && axi.w_ready) begin
      w_beats++;
      w_seen = axi.w_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
    axi.b_valid = 1'b0; axi.b_id = '0; axi.b_resp = '0; axi.b_user = '0;
    axi.r_valid = 1'b0; axi.r_id = '0; axi.r_data = '0; axi.r_resp = '0;
    axi.r_last = 1'b0; axi.r_user = '0;
  endtask

  task automatic send_cmd(input logic we, input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] strb);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = data;
    cmd_strb = strb; cmd_size = 3'd3;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_write(input logic [1:0] bresp, input logic [3:0] bid);
    axi.aw_ready = 1'b1; axi.w_ready = 1'b1;
    step();
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
    axi.b_valid = 1'b1; axi.b_resp = bresp; axi.b_id = bid;
    step();
    axi.b_valid = 1'b0;
  endtask

  task automatic finish_read(input logic [63:0] data, input logic [1:0] rresp,
                             input logic [3:0] rid, input logic rlast);
    axi.ar_ready = 1'b1;
    step();
    axi.ar_ready = 1'b0;
    axi.r_valid = 1'b1; axi.r_data = data; axi.r_resp = rresp; axi.r_id = rid; axi.r_last = rlast;
    step();
    axi.r_valid = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({cmd_ready, axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, rsp_valid} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {cmd_ready, axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, rsp_valid});
    end
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++; $display("FAIL reset_release_ready: cmd_ready=%b required 0", cmd_ready);
    end
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_first_cycle_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write_same_cycle();
    int a0 = aw_beats;
    int w0 = w_beats;
    send_cmd(1'b1, 64'h5000_0050, 64'h1, 8'hFF);
    checks++;
    if ({axi.aw_valid, axi.w_valid, axi.ar_valid, cmd_ready} !== 4'b1100) begin
      failures++; $display("FAIL wr_valids: {aw,w,ar,cmd_ready}=%b required 1100",
                           {axi.aw_valid, axi.w_valid, axi.ar_valid, cmd_ready});
    end
    checks++;
    if (axi.aw_addr !== 64'h5000_0050 || axi.w_data !== 64'h1 || axi.w_strb !== 8'hFF) begin
      failures++; $display("FAIL wr_payload: addr=%h data=%h strb=%h required 5000_0050/1/ff",
                           axi.aw_addr, axi.w_data, axi.w_strb);
    end
    checks++;
    if ({axi.aw_len, axi.aw_burst, axi.aw_size, axi.w_last, axi.aw_id, axi.aw_atop} !== {8'd0, 2'b01, 3'd3, 1'b1, 4'd0, 6'd0}) begin
      failures++; $display("FAIL wr_fixed_fields: len=%h burst=%b size=%0d last=%b id=%h atop=%h",
                           axi.aw_len, axi.aw_burst, axi.aw_size, axi.w_last, axi.aw_id, axi.aw_atop);
    end
    axi.aw_ready = 1'b1; axi.w_ready = 1'b1;
    step();
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
    checks++;
    if ({axi.aw_valid, axi.w_valid, axi.b_ready} !== 3'b001) begin
      failures++; $display("FAIL wr_after_hs: {aw,w,b_ready}=%b required 001",
                           {axi.aw_valid, axi.w_valid, axi.b_ready});
    end
    step();
    axi.b_valid = 1'b1; axi.b_resp = 2'b00; axi.b_id = 4'd0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL wr_rsp_early: rsp_valid=%b required 0", rsp_valid);
    end
    step();
    axi.b_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_tmo, rsp_resp, axi.b_ready} !== 6'b100000 || rsp_rdata !== 64'h0) begin
      failures++; $display("FAIL wr_rsp: {valid,err,tmo,resp,b_ready}=%b rdata=%h required 100000/0",
                           {rsp_valid, rsp_err, rsp_tmo, rsp_resp, axi.b_ready}, rsp_rdata);
    end
    checks++;
    if (aw_beats - a0 !== 1 || w_beats - w0 !== 1) begin
      failures++; $display("FAIL wr_beats: aw=%0d w=%0d required 1/1", aw_beats - a0, w_beats - w0);
    end
    take_rsp();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++; $display("FAIL wr_rsp_hs: {rsp_valid,cmd_ready}=%b required 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_split_order();
    for (int k = 0; k < 2; k++) begin
      int a0 = aw_beats;
      int w0 = w_beats;
      logic [1:0] exp = (k == 0) ? 2'b10 : 2'b01;
      send_cmd(1'b1, 64'h5000_0060, 64'h1234 + 64'(k), 8'h0F);
      if (k == 0) axi.w_ready = 1'b1;
      else        axi.aw_ready = 1'b1;
      step();
      axi.w_ready = 1'b0; axi.aw_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({axi.aw_valid, axi.w_valid, axi.b_ready} !== {exp, 1'b0}) begin
          failures++; $display("FAIL split_%0d_wait%0d: {aw,w,b_ready}=%b required %b0",
                               k, i, {axi.aw_valid, axi.w_valid, axi.b_ready}, exp);
        end
        if (i != 2) step();
      end
      if (k == 0) axi.aw_ready = 1'b1;
      else        axi.w_ready = 1'b1;
      step();
      axi.w_ready = 1'b0; axi.aw_ready = 1'b0;
      checks++;
      if ({axi.aw_valid, axi.w_valid, axi.b_ready} !== 3'b001) begin
        failures++; $display("FAIL split_%0d_done: {aw,w,b_ready}=%b required 001",
                             k, {axi.aw_valid, axi.w_valid, axi.b_ready});
      end
      axi.b_valid = 1'b1; axi.b_resp = 2'b00; axi.b_id = 4'd0;
      step();
      axi.b_valid = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err, rsp_tmo} !== 3'b100 || aw_beats - a0 !== 1 || w_beats - w0 !== 1) begin
        failures++; $display("FAIL split_%0d_rsp: {valid,err,tmo}=%b aw=%0d w=%0d required 100/1/1",
                             k, {rsp_valid, rsp_err, rsp_tmo}, aw_beats - a0, w_beats - w0);
      end
      take_rsp();
    end
  endtask

  task automatic test_read_after_write();
    send_cmd(1'b1, 64'h8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    finish_write(2'b00, 4'd0);
    take_rsp();
    send_cmd(1'b0, 64'h8000_0000, 64'h0, 8'h00);
    checks++;
    if ({axi.ar_valid, axi.aw_valid, axi.w_valid} !== 3'b100 || axi.ar_addr !== 64'h8000_0000 ||
        {axi.ar_len, axi.ar_burst, axi.ar_size} !== {8'd0, 2'b01, 3'd3}) begin
      failures++; $display("FAIL rd_request: {ar,aw,w}=%b addr=%h len=%h burst=%b size=%0d",
                           {axi.ar_valid, axi.aw_valid, axi.w_valid}, axi.ar_addr,
                           axi.ar_len, axi.ar_burst, axi.ar_size);
    end
    finish_read(w_seen, 2'b00, 4'd0, 1'b1);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hDEAD_BEEF_CAFE_F00D || {rsp_resp, rsp_err, rsp_tmo} !== 4'b0000) begin
      failures++; $display("FAIL rd_data: valid=%b rdata=%h {resp,err,tmo}=%b required 1/deadbeefcafef00d/0000",
                           rsp_valid, rsp_rdata, {rsp_resp, rsp_err, rsp_tmo});
    end
    take_rsp();
  endtask

  task automatic test_error_responses();
    send_cmd(1'b1, 64'h0, 64'h55, 8'h01);
    finish_write(2'b11, 4'd0);
    checks++;
    if ({rsp_valid, rsp_resp, rsp_err, rsp_tmo} !== 5'b1_11_1_0) begin
      failures++; $display("FAIL err_decerr: {valid,resp,err,tmo}=%b required 11110",
                           {rsp_valid, rsp_resp, rsp_err, rsp_tmo});
    end
    take_rsp();
    send_cmd(1'b0, 64'h8000_0000, 64'h0, 8'h00);
    finish_read(64'h0000_1111_2222_3333, 2'b00, 4'd1, 1'b1);
    checks++;
    if ({rsp_valid, rsp_resp, rsp_err, rsp_tmo} !== 5'b1_00_1_0 || rsp_rdata !== 64'h0000_1111_2222_3333) begin
      failures++; $display("FAIL err_rid: {valid,resp,err,tmo}=%b rdata=%h required 10010/0000111122223333",
                           {rsp_valid, rsp_resp, rsp_err, rsp_tmo}, rsp_rdata);
    end
    take_rsp();
    send_cmd(1'b0, 64'h8000_0010, 64'h0, 8'h00);
    finish_read(64'h77, 2'b00, 4'd0, 1'b0);
    checks++;
    if ({rsp_valid, rsp_resp, rsp_err, rsp_tmo} !== 5'b1_00_1_0) begin
      failures++; $display("FAIL err_rlast: {valid,resp,err,tmo}=%b required 10010",
                           {rsp_valid, rsp_resp, rsp_err, rsp_tmo});
    end
    take_rsp();
  endtask

  task automatic test_hold_and_reset();
    send_cmd(1'b0, 64'h8000_0008, 64'h0, 8'h00);
    finish_read(64'h0123_4567_89AB_CDEF, 2'b10, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, rsp_resp, rsp_err, rsp_tmo} !== 5'b1_10_1_0 || rsp_rdata !== 64'h0123_4567_89AB_CDEF) begin
        failures++; $display("FAIL hold_%0d: {valid,resp,err,tmo}=%b rdata=%h required 11010/0123456789abcdef",
                             i, {rsp_valid, rsp_resp, rsp_err, rsp_tmo}, rsp_rdata);
      end
      step();
    end
    take_rsp();
    send_cmd(1'b0, 64'h8000_0018, 64'h0, 8'h00);
    axi.ar_ready = 1'b1;
    step();
    axi.ar_ready = 1'b0;
    checks++;
    if ({axi.ar_valid, axi.r_ready} !== 2'b01) begin
      failures++; $display("FAIL mid_read: {ar,r_ready}=%b required 01", {axi.ar_valid, axi.r_ready});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, rsp_valid} !== 7'b0) begin
      failures++; $display("FAIL async_reset: got %b required 0000000",
                           {cmd_ready, axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, rsp_valid});
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_recover: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    send_cmd(1'b1, 64'h4000_0000, 64'hAA, 8'hFF);
    while (rsp_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != 17) begin
      failures++; $display("FAIL tmo_latency: rsp after %0d cycles required 17", n);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_tmo, axi.aw_valid, axi.w_valid} !== 5'b11111 || rsp_rdata !== 64'h0) begin
      failures++; $display("FAIL tmo_rsp: {valid,err,tmo,aw,w}=%b rdata=%h required 11111/0",
                           {rsp_valid, rsp_err, rsp_tmo, axi.aw_valid, axi.w_valid}, rsp_rdata);
    end
    take_rsp();
    cmd_valid = 1'b1; cmd_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({cmd_ready, rsp_valid, axi.aw_valid} !== 3'b001) begin
        failures++; $display("FAIL fault_%0d: {cmd_ready,rsp_valid,aw}=%b required 001",
                             i, {cmd_ready, rsp_valid, axi.aw_valid});
      end
      step();
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({cmd_ready, axi.aw_valid, axi.w_valid} !== 3'b000) begin
      failures++; $display("FAIL fault_reset: {cmd_ready,aw,w}=%b required 000",
                           {cmd_ready, axi.aw_valid, axi.w_valid});
    end
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL fault_recover: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_size = 3'd3; rsp_ready = 1'b0;
    slave_idle();
    test_reset();
    test_write_same_cycle();
    test_split_order();
    test_read_after_write();
    test_error_responses();
    test_hold_and_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
